// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage between the ALU and write-back. It issues one
// request on a req/ready data bus per instruction and freezes the datapath until it completes.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] readdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state, stateNext;
  logic [7:0]  cnt;
  logic [1:0]  offQ, sizeQ;
  logic        unsQ, weQ;
  logic [3:0]  beQ, beNext;
  logic [31:0] addrQ, wdataQ, wdataNext, fmtData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic        badAccess;

  // Request-side checks and lane encoding, evaluated while IDLE.
  always_comb begin
    badAccess = (size_i == 2'b11) ||
                (size_i == 2'b01 && addr_i[0]) ||
                (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    beNext    = 4'b1111;
    wdataNext = wdata_i;
    case (size_i)
      2'b00: begin
        beNext    = 4'b0001 << addr_i[1:0];
        wdataNext = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        beNext    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension from the latched offset.
  always_comb begin
    byteSel = bus_rdata_i[8*offQ +: 8];
    halfSel = offQ[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (sizeQ)
      2'b00:   fmtData = {{24{~unsQ & byteSel[7]}}, byteSel};
      2'b01:   fmtData = {{16{~unsQ & halfSel[15]}}, halfSel};
      default: fmtData = bus_rdata_i;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (mem_read_i && mem_write_i)    stateNext = ERR;
        else if (mem_read_i || mem_write_i) stateNext = badAccess ? ERR : REQ;
      end
      REQ: begin
        if (bus_ready_i)                     stateNext = DONE;
        else if (cnt == 8'(TIMEOUT - 1))     stateNext = ERR;
      end
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      offQ       <= '0;
      sizeQ      <= '0;
      unsQ       <= 1'b0;
      weQ        <= 1'b0;
      beQ        <= '0;
      addrQ      <= '0;
      wdataQ     <= '0;
      readdata_o <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && stateNext == REQ) begin
        cnt    <= '0;
        weQ    <= mem_write_i;
        addrQ  <= {addr_i[31:2], 2'b00};
        offQ   <= addr_i[1:0];
        beQ    <= beNext;
        wdataQ <= wdataNext;
        sizeQ  <= size_i;
        unsQ   <= unsigned_i;
      end
      if (state == REQ) begin
        cnt <= cnt + 8'd1;
        if (bus_ready_i && !weQ) readdata_o <= fmtData;
      end
    end
  end

  // Stall is gated by reset so a held load control cannot keep it high during reset.
  assign stall_o     = rst_n & ((state == IDLE && (mem_read_i ^ mem_write_i)) || state == REQ);
  assign err_o       = (state == ERR);
  assign bus_req_o   = (state == REQ);
  assign bus_we_o    = (state == REQ) & weQ;
  assign bus_be_o    = (state == REQ) ? beQ : 4'b0000;
  assign bus_addr_o  = addrQ;
  assign bus_wdata_o = wdataQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of single accesses with a bus
// scoreboard, plus hand-written timeout and mid-request reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i, mem_write_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i, readdata_o;
  logic        stall_o, err_o, bus_req_o, bus_we_o, bus_ready_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .readdata_o(readdata_o), .stall_o(stall_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] bAddr, bWdata, rdExp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } busExp_t;

  vec_t        vecs[13];
  busExp_t     sbq[$];
  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] rdModel = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic popBus();
    busExp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("bus_we",    {31'd0, bus_we_o}, {31'd0, e.we});
      chk("bus_addr",  bus_addr_o, e.addr);
      chk("bus_be",    {28'd0, bus_be_o}, {28'd0, e.be});
      chk("bus_wdata", bus_wdata_o, e.wdata);
    end
  endtask

  task automatic idleInputs();
    mem_read_i = 0; mem_write_i = 0; size_i = 0; unsigned_i = 0;
    addr_i = 0; wdata_i = 0; bus_ready_i = 0; bus_rdata_i = 0;
  endtask

  task automatic runVec(input vec_t v);
    @(negedge clk);
    mem_read_i = v.rd; mem_write_i = v.wr; size_i = v.size; unsigned_i = v.uns;
    addr_i = v.addr; wdata_i = v.wdata; bus_ready_i = 1'b1; bus_rdata_i = v.rdata;
    if (!v.err) sbq.push_back('{we: v.wr, addr: v.bAddr, be: v.be, wdata: v.bWdata});
    #1 chk("stall_c0", {31'd0, stall_o}, {31'd0, v.rd ^ v.wr});
    @(negedge clk); #1;
    if (v.err) begin
      chk("err_pulse", {31'd0, err_o}, 32'd1);
      chk("err_req",   {31'd0, bus_req_o}, 32'd0);
      chk("err_stall", {31'd0, stall_o}, 32'd0);
      chk("err_rdata", readdata_o, rdModel);
      idleInputs();
      @(negedge clk); #1;
      chk("err_1cyc", {31'd0, err_o}, 32'd0);
    end else begin
      chk("req_c1",   {31'd0, bus_req_o}, 32'd1);
      chk("stall_c1", {31'd0, stall_o}, 32'd1);
      if (bus_req_o && bus_ready_i) popBus();
      @(negedge clk); #1;
      if (v.rd) rdModel = v.rdExp;
      chk("done_stall", {31'd0, stall_o}, 32'd0);
      chk("done_req",   {31'd0, bus_req_o}, 32'd0);
      chk("readdata",   readdata_o, rdModel);
      idleInputs();
    end
  endtask

  initial begin
    int reqCnt;
    bit sawErr;
    //           rd wr size uns addr          wdata         rdata         err be       bAddr         bWdata        rdExp
    vecs[0]  = '{1, 0, 2'b10, 0, 32'h10, 32'h11111111, 32'hDEADBEEF, 0, 4'b1111, 32'h10, 32'h11111111, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 2'b00, 0, 32'h13, 32'h000000AA, 32'h80112233, 0, 4'b1000, 32'h10, 32'hAAAAAAAA, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 2'b00, 1, 32'h13, 32'h000000AA, 32'h80112233, 0, 4'b1000, 32'h10, 32'hAAAAAAAA, 32'h00000080};
    vecs[3]  = '{1, 0, 2'b01, 0, 32'h02, 32'h00000000, 32'h80015555, 0, 4'b1100, 32'h00, 32'h00000000, 32'hFFFF8001};
    vecs[4]  = '{1, 0, 2'b01, 1, 32'h00, 32'h00000000, 32'h1234F00F, 0, 4'b0011, 32'h00, 32'h00000000, 32'h0000F00F};
    vecs[5]  = '{1, 0, 2'b00, 0, 32'h11, 32'h00000000, 32'h00007F00, 0, 4'b0010, 32'h10, 32'h00000000, 32'h0000007F};
    vecs[6]  = '{0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'hFFFFFFFF, 0, 4'b1100, 32'h20, 32'hABCDABCD, 32'h0};
    vecs[7]  = '{0, 1, 2'b00, 0, 32'h05, 32'h000000EE, 32'h0,        0, 4'b0010, 32'h04, 32'hEEEEEEEE, 32'h0};
    vecs[8]  = '{0, 1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'h08, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1, 0, 2'b10, 0, 32'h06, 32'h0,        32'h0,        1, 4'b0000, 32'h0,  32'h0,        32'h0};
    vecs[10] = '{0, 1, 2'b01, 0, 32'h01, 32'h0,        32'h0,        1, 4'b0000, 32'h0,  32'h0,        32'h0};
    vecs[11] = '{1, 0, 2'b11, 0, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0,  32'h0,        32'h0};
    vecs[12] = '{1, 1, 2'b10, 0, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0,  32'h0,        32'h0};

    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_readdata", readdata_o, 32'h0);
    chk("rst_stall",    {31'd0, stall_o}, 32'd0);
    chk("rst_err",      {31'd0, err_o}, 32'd0);
    chk("rst_req",      {31'd0, bus_req_o}, 32'd0);
    chk("rst_be",       {28'd0, bus_be_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) runVec(vecs[i]);
    chk("sb_drained", sbq.size(), 32'd0);

    // Timeout: ready held low, request must last exactly TIMEOUT cycles.
    @(negedge clk);
    mem_read_i = 1; size_i = 2'b10; addr_i = 32'h40; bus_ready_i = 0;
    reqCnt = 0; sawErr = 0;
    for (int c = 0; c < 20 && !sawErr; c++) begin
      @(negedge clk); #1;
      if (bus_req_o) reqCnt++;
      if (err_o) begin
        sawErr = 1;
        chk("to_err_stall", {31'd0, stall_o}, 32'd0);
      end
    end
    chk("to_req_cycles", reqCnt, 32'd4);
    chk("to_err_seen",   {31'd0, sawErr}, 32'd1);
    idleInputs();
    bus_ready_i = 1; bus_rdata_i = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("late_ready_req", {31'd0, bus_req_o}, 32'd0);
      chk("late_ready_rd",  readdata_o, rdModel);
    end
    idleInputs();

    // Reset in the middle of a request drops it without a clock edge.
    @(negedge clk);
    mem_read_i = 1; size_i = 2'b10; addr_i = 32'h80; bus_ready_i = 0;
    @(negedge clk); #1;
    chk("mid_req_up", {31'd0, bus_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req",   {31'd0, bus_req_o}, 32'd0);
    chk("rst_async_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_async_rd",    readdata_o, 32'h0);
    @(negedge clk);
    idleInputs();
    rst_n = 1'b1;
    rdModel = '0;
    @(negedge clk); #1;
    chk("post_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("post_rst_rd",  readdata_o, 32'h0);
    runVec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
